// File: rtl/alarm_scheduler.sv
// Alarm scheduler with APB register interface.
// Four BCD alarm slots are compared against the current time on every minute tick. A match
// starts ringing; the user can stop or snooze, and an unanswered alarm times out and is
// flagged as missed. A match while already busy is flagged as overlap.
//
// Ports:
//   pclk_i, presetn_i          clock, asynchronous active-low reset
//   paddr_i .. pslverr_o       APB slave (zero wait states, 0x00..0x18)
//   time_now_i                 current BCD time {hourdec, hourone, mindec, minone}
//   minute_tick_i              one-cycle pulse per minute change
//   stop_btn_i, snooze_btn_i   pre-synchronized one-cycle button pulses
//   ring_o                     buzzer enable (only while ringing)
//   irq_o                      ring_o | missed | overlap
module alarm_scheduler (
  input  logic        pclk_i,
  input  logic        presetn_i,
  input  logic [31:0] paddr_i,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [31:0] pwdata_i,
  input  logic [3:0]  pstrb_i,
  output logic        pready_o,
  output logic [31:0] prdata_o,
  output logic        pslverr_o,
  input  logic [15:0] time_now_i,
  input  logic        minute_tick_i,
  input  logic        stop_btn_i,
  input  logic        snooze_btn_i,
  output logic        ring_o,
  output logic        irq_o
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRinging = 2'd1,
    StSnooze  = 2'd2
  } state_e;

  state_e            state_q;
  logic [3:0][16:0]  alarm_q;
  logic [5:0]        snooze_min_q;
  logic [5:0]        timeout_min_q;
  logic [5:0]        cnt_q;
  logic [1:0]        slot_q;
  logic              ring_q;
  logic              missed_q;
  logic              overlap_q;

  // APB decode
  logic       access;
  logic       addr_err;
  logic       wr;
  logic [2:0] reg_idx;
  logic       cmd_wr;
  logic       status_wr;

  assign access    = psel_i & penable_i;
  assign addr_err  = (paddr_i > 32'h18) | (paddr_i[1:0] != 2'b00);
  assign wr        = access & pwrite_i & ~addr_err;
  assign reg_idx   = paddr_i[4:2];
  assign cmd_wr    = wr & (reg_idx == 3'd5) & pstrb_i[0];
  assign status_wr = wr & (reg_idx == 3'd6) & pstrb_i[0];
  assign pready_o  = access;
  assign pslverr_o = access & addr_err;

  // Configuration registers
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      alarm_q       <= '0;
      snooze_min_q  <= 6'd5;
      timeout_min_q <= 6'd10;
    end else if (wr) begin
      if (reg_idx < 3'd4) begin
        if (pstrb_i[0]) alarm_q[reg_idx[1:0]][7:0]  <= pwdata_i[7:0];
        if (pstrb_i[1]) alarm_q[reg_idx[1:0]][15:8] <= pwdata_i[15:8];
        if (pstrb_i[2]) alarm_q[reg_idx[1:0]][16]   <= pwdata_i[16];
      end else if (reg_idx == 3'd4) begin
        if (pstrb_i[0]) snooze_min_q  <= pwdata_i[5:0];
        if (pstrb_i[1]) timeout_min_q <= pwdata_i[13:8];
      end
    end
  end

  // Slot match: scan high to low so the lowest matching index wins
  logic       hit;
  logic [1:0] hit_slot;
  logic       match;

  always_comb begin
    hit      = 1'b0;
    hit_slot = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (alarm_q[i][16] && (alarm_q[i][15:0] == time_now_i)) begin
        hit      = 1'b1;
        hit_slot = 2'(i);
      end
    end
  end

  assign match = hit & minute_tick_i;

  // Events, resolved with priority stop > snooze > tick
  logic stop_ev;
  logic snooze_ev;
  logic snooze_go;
  logic timeout_ev;
  logic overlap_ev;

  assign stop_ev    = stop_btn_i | (cmd_wr & pwdata_i[0]);
  assign snooze_ev  = snooze_btn_i | (cmd_wr & pwdata_i[1]);
  assign snooze_go  = snooze_ev & (snooze_min_q != 6'd0);
  // A counter loaded with zero means the timeout is disabled for this ring
  assign timeout_ev = (state_q == StRinging) & ~stop_ev & ~snooze_go & minute_tick_i &
                      (cnt_q == 6'd1);
  assign overlap_ev = match & (state_q != StIdle);

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      state_q <= StIdle;
      ring_q  <= 1'b0;
      cnt_q   <= '0;
      slot_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (match) begin
            state_q <= StRinging;
            ring_q  <= 1'b1;
            slot_q  <= hit_slot;
            cnt_q   <= timeout_min_q;
          end
        end
        StRinging: begin
          if (stop_ev) begin
            state_q <= StIdle;
            ring_q  <= 1'b0;
          end else if (snooze_go) begin
            state_q <= StSnooze;
            ring_q  <= 1'b0;
            cnt_q   <= snooze_min_q;
          end else if (minute_tick_i && (cnt_q != 6'd0)) begin
            if (cnt_q == 6'd1) begin
              state_q <= StIdle;
              ring_q  <= 1'b0;
            end
            cnt_q <= cnt_q - 6'd1;
          end
        end
        StSnooze: begin
          if (stop_ev) begin
            state_q <= StIdle;
            ring_q  <= 1'b0;
          end else if (minute_tick_i) begin
            if (cnt_q == 6'd1) begin
              state_q <= StRinging;
              ring_q  <= 1'b1;
              cnt_q   <= timeout_min_q;
            end else begin
              cnt_q <= cnt_q - 6'd1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          ring_q  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flags: a set event in the same cycle as a W1C wins
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      missed_q  <= 1'b0;
      overlap_q <= 1'b0;
    end else begin
      missed_q  <= timeout_ev | (missed_q & ~(status_wr & pwdata_i[4]));
      overlap_q <= overlap_ev | (overlap_q & ~(status_wr & pwdata_i[5]));
    end
  end

  // Read mux
  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    unique case (reg_idx)
      3'd0, 3'd1, 3'd2, 3'd3: rdata = {15'd0, alarm_q[reg_idx[1:0]]};
      3'd4:                   rdata = {18'd0, timeout_min_q, 2'd0, snooze_min_q};
      3'd6:                   rdata = {26'd0, overlap_q, missed_q, slot_q, state_q};
      default:                rdata = '0;
    endcase
  end

  assign prdata_o = (access & ~addr_err) ? rdata : 32'd0;
  assign ring_o   = ring_q;
  assign irq_o    = ring_q | missed_q | overlap_q;

endmodule

// File: tb/tb_alarm_scheduler.sv
module tb_alarm_scheduler;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic [31:0] paddr = '0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic [15:0] time_now = '0;
  logic        minute_tick = 1'b0;
  logic        stop_btn = 1'b0;
  logic        snooze_btn = 1'b0;
  logic        ring;
  logic        irq;

  alarm_scheduler dut (
    .pclk_i       (pclk),
    .presetn_i    (presetn),
    .paddr_i      (paddr),
    .psel_i       (psel),
    .penable_i    (penable),
    .pwrite_i     (pwrite),
    .pwdata_i     (pwdata),
    .pstrb_i      (pstrb),
    .pready_o     (pready),
    .prdata_o     (prdata),
    .pslverr_o    (pslverr),
    .time_now_i   (time_now),
    .minute_tick_i(minute_tick),
    .stop_btn_i   (stop_btn),
    .snooze_btn_i (snooze_btn),
    .ring_o       (ring),
    .irq_o        (irq)
  );

  always #5 pclk = ~pclk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic err);
    @(negedge pclk);
    psel = 1'b1; pwrite = 1'b1; paddr = addr; pwdata = data; pstrb = strb;
    @(negedge pclk);
    penable = 1'b1;
    #1 err = pslverr;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic err);
    @(negedge pclk);
    psel = 1'b1; pwrite = 1'b0; paddr = addr;
    @(negedge pclk);
    penable = 1'b1;
    #1 data = prdata;
    err = pslverr;
    check("pready", 32'(pready), 32'd1);
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic e;
    apb_write(addr, data, 4'hF, e);
  endtask

  task automatic check_status(input string name, input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    apb_read(32'h18, d, e);
    check(name, d, exp);
  endtask

  // One-cycle pulse; returns at the negedge after the capturing edge
  task automatic pulse(input logic t, input logic s, input logic z);
    @(negedge pclk);
    minute_tick = t; stop_btn = s; snooze_btn = z;
    @(negedge pclk);
    minute_tick = 1'b0; stop_btn = 1'b0; snooze_btn = 1'b0;
  endtask

  task automatic trigger(input logic [15:0] bcd);
    time_now = bcd;
    pulse(1'b1, 1'b0, 1'b0);
    time_now = 16'h0000;
  endtask

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[22];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic        e;

    vecs[0]  = '{1'b0, 32'h10, 32'h0,        4'h0, 1'b0, 32'h0A05};
    vecs[1]  = '{1'b0, 32'h00, 32'h0,        4'h0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 32'h18, 32'h0,        4'h0, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 32'h00, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 32'h00, 32'h0,        4'h0, 1'b0, 32'h1FFFF};
    vecs[5]  = '{1'b1, 32'h00, 32'h0,        4'h1, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 32'h00, 32'h0,        4'h0, 1'b0, 32'h1FF00};
    vecs[7]  = '{1'b1, 32'h00, 32'h12345678, 4'h2, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 32'h00, 32'h0,        4'h0, 1'b0, 32'h15600};
    vecs[9]  = '{1'b1, 32'h00, 32'h0,        4'hF, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 32'h1C, 32'h0,        4'h0, 1'b1, 32'h0};
    vecs[11] = '{1'b0, 32'h02, 32'h0,        4'h0, 1'b1, 32'h0};
    vecs[12] = '{1'b1, 32'h11, 32'hFFFF,     4'hF, 1'b1, 32'h0};
    vecs[13] = '{1'b0, 32'h10, 32'h0,        4'h0, 1'b0, 32'h0A05};
    vecs[14] = '{1'b1, 32'h10, 32'h3F3F,     4'h1, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 32'h10, 32'h0,        4'h0, 1'b0, 32'h0A3F};
    vecs[16] = '{1'b1, 32'h10, 32'h0A05,     4'hF, 1'b0, 32'h0};
    vecs[17] = '{1'b1, 32'h18, 32'hFF,       4'hF, 1'b0, 32'h0};
    vecs[18] = '{1'b0, 32'h18, 32'h0,        4'h0, 1'b0, 32'h0};
    vecs[19] = '{1'b1, 32'h14, 32'h0,        4'hF, 1'b0, 32'h0};
    vecs[20] = '{1'b0, 32'h14, 32'h0,        4'h0, 1'b0, 32'h0};
    vecs[21] = '{1'b1, 32'h04, 32'h10730,    4'hF, 1'b0, 32'h0};

    // Reset state
    #3;
    check("reset_ring", 32'(ring), 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    check("reset_prdata", prdata, 32'd0);
    check("reset_pslverr", 32'(pslverr), 32'd0);
    @(negedge pclk);
    @(negedge pclk);
    presetn = 1'b1;

    // Register access table
    for (int i = 0; i < 22; i++) begin
      if (vecs[i].is_wr) begin
        apb_write(vecs[i].addr, vecs[i].data, vecs[i].strb, e);
        check($sformatf("vec%0d_wr_err", i), 32'(e), 32'(vecs[i].exp_err));
      end else begin
        apb_read(vecs[i].addr, d, e);
        check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
        check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
      end
    end

    // Slot 1 at 07:30 rings; STATUS = RINGING, slot 1
    trigger(16'h0730);
    check("a_ring", 32'(ring), 32'd1);
    check("a_irq", 32'(irq), 32'd1);
    check_status("a_status", 32'h05);
    pulse(1'b0, 1'b1, 1'b0);
    check("a_stop_ring", 32'(ring), 32'd0);
    check("a_stop_irq", 32'(irq), 32'd0);
    wr(32'h04, 32'h0);

    // Slots 0 and 2 both at 06:00: lowest wins, second match flags overlap
    wr(32'h00, 32'h10600);
    wr(32'h08, 32'h10600);
    trigger(16'h0600);
    check_status("b_status", 32'h01);
    trigger(16'h0600);
    check("b_ring", 32'(ring), 32'd1);
    check_status("b_overlap", 32'h21);
    wr(32'h14, 32'h1);
    check("b_cmdstop_ring", 32'(ring), 32'd0);
    check("b_irq_overlap", 32'(irq), 32'd1);
    check_status("b_idle_status", 32'h20);
    wr(32'h18, 32'h20);
    check_status("b_w1c", 32'h00);
    check("b_irq_clear", 32'(irq), 32'd0);

    // Snooze for 5 minutes, then stop+snooze together stops
    trigger(16'h0600);
    pulse(1'b0, 1'b0, 1'b1);
    check("c_snooze_ring", 32'(ring), 32'd0);
    check_status("c_snooze_status", 32'h02);
    for (int k = 0; k < 4; k++) pulse(1'b1, 1'b0, 1'b0);
    check("c_tick4_ring", 32'(ring), 32'd0);
    pulse(1'b1, 1'b0, 1'b0);
    check("c_tick5_ring", 32'(ring), 32'd1);
    pulse(1'b0, 1'b1, 1'b1);
    check("c_both_ring", 32'(ring), 32'd0);
    check_status("c_both_status", 32'h00);

    // snooze_min = 0 makes snooze a no-op
    apb_write(32'h10, 32'h0, 4'h1, e);
    trigger(16'h0600);
    pulse(1'b0, 1'b0, 1'b1);
    check("c_snz0_ring", 32'(ring), 32'd1);
    pulse(1'b0, 1'b1, 1'b0);

    // Timeout of 2 minutes -> missed
    wr(32'h10, 32'h0205);
    trigger(16'h0600);
    pulse(1'b1, 1'b0, 1'b0);
    check("d_tick1_ring", 32'(ring), 32'd1);
    pulse(1'b1, 1'b0, 1'b0);
    check("d_tick2_ring", 32'(ring), 32'd0);
    check("d_missed_irq", 32'(irq), 32'd1);
    check_status("d_missed_status", 32'h10);
    wr(32'h18, 32'h10);
    check_status("d_w1c", 32'h00);
    check("d_irq_clear", 32'(irq), 32'd0);

    // W1C in the same cycle as the timeout that sets missed
    trigger(16'h0600);
    pulse(1'b1, 1'b0, 1'b0);
    @(negedge pclk);
    psel = 1'b1; pwrite = 1'b1; paddr = 32'h18; pwdata = 32'h10; pstrb = 4'h1;
    @(negedge pclk);
    penable = 1'b1; minute_tick = 1'b1;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; minute_tick = 1'b0;
    check_status("e_set_wins", 32'h10);
    wr(32'h18, 32'h10);

    // timeout_min = 0 never times out
    wr(32'h10, 32'h0005);
    trigger(16'h0600);
    for (int k = 0; k < 3; k++) pulse(1'b1, 1'b0, 1'b0);
    check("f_no_timeout_ring", 32'(ring), 32'd1);

    // Asynchronous reset while ringing
    @(negedge pclk);
    presetn = 1'b0;
    #1;
    check("g_async_ring", 32'(ring), 32'd0);
    check("g_async_irq", 32'(irq), 32'd0);
    @(negedge pclk);
    presetn = 1'b1;
    apb_read(32'h10, d, e);
    check("g_cfg_reset", d, 32'h0A05);
    apb_read(32'h00, d, e);
    check("g_alarm0_reset", d, 32'h0);
    check_status("g_status_reset", 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alarm_scheduler.md
ALARM_SCHEDULER -- requirements
Module: alarm_scheduler

Interface
REQ-001 SHALL have pclk_i, input, 1, clock; all state updates on rising edge.
REQ-002 SHALL have presetn_i, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have paddr_i, input, 32, APB address; only bits [4:0] are decoded.
REQ-004 SHALL have psel_i, penable_i and pwrite_i, input, 1 each, APB control.
REQ-005 SHALL have pwdata_i (32) and pstrb_i (4), inputs, APB write data and byte strobes.
REQ-006 SHALL have pready_o (1), prdata_o (32) and pslverr_o (1), outputs, APB response.
REQ-007 SHALL have time_now_i, input, 16, current BCD time {hourdec,hourone,mindec,minone}.
REQ-008 SHALL have minute_tick_i, input, 1, one-cycle pulse on each minute change.
REQ-009 SHALL have stop_btn_i and snooze_btn_i, inputs, 1 each, pre-synchronized one-cycle pulses.
REQ-010 SHALL have ring_o, output, 1, buzzer enable.
REQ-011 SHALL have irq_o, output, 1, equal to ring_o OR missed OR overlap.

Function
REQ-012 pready_o SHALL equal psel_i & penable_i, giving zero wait states; a write commits when psel_i & penable_i & pwrite_i.
REQ-013 Register map SHALL be:
- 0x00/0x04/0x08/0x0C: ALARM0..3, [15:0] BCD time, [16] enable, RW.
- 0x10: CFG, [5:0] snooze_min, [13:8] timeout_min, RW.
- 0x14: CMD, write-only, [0] stop, [1] snooze; reads 0.
- 0x18: STATUS, [1:0] state (0 IDLE, 1 RINGING, 2 SNOOZE), [3:2] active slot, [4] missed, [5] overlap. Bits 4 and 5 are write-1-to-clear; all other STATUS bits are read-only.
REQ-014 Writes SHALL honour pstrb_i per byte; unimplemented bits SHALL read 0.
REQ-015 In the access phase, pslverr_o SHALL be 1 when paddr_i > 0x18 or paddr_i[1:0] != 0; an errored access SHALL write nothing and return prdata_o = 0.
REQ-016 prdata_o SHALL be driven combinationally during the access phase and SHALL be 0 otherwise.
REQ-017 The FSM SHALL have states IDLE, RINGING and SNOOZE, with ring_o = 1 only in RINGING.
REQ-018 IDLE->RINGING SHALL occur when minute_tick_i = 1 and any enabled slot equals time_now_i:
- the lowest matching index wins and is latched as the active slot;
- the timeout counter loads timeout_min.
REQ-019 A stop event (stop_btn_i, or a CMD write with bit0 = 1) in RINGING or SNOOZE SHALL go to IDLE on the next edge.
REQ-020 A snooze event in RINGING with snooze_min != 0 SHALL go to SNOOZE and load the counter with snooze_min; snooze_min = 0 SHALL make the snooze event a no-op.
REQ-021 In RINGING with timeout_min != 0, each minute_tick_i SHALL decrement the counter; a tick at counter = 1 SHALL go to IDLE and set missed. timeout_min = 0 SHALL disable the timeout.
REQ-022 In SNOOZE, each tick SHALL decrement the counter; a tick at counter = 1 SHALL go to RINGING and reload timeout_min.
REQ-023 Simultaneous events SHALL resolve with priority stop > snooze > tick.
REQ-024 A slot match while in RINGING or SNOOZE SHALL set overlap and SHALL NOT change state or the active slot.
REQ-025 Slot enables SHALL persist after ringing (daily repeat).
REQ-026 ALARM and CFG writes SHALL NOT affect an in-progress counter; new values apply at the next load.
REQ-027 A W1C write to STATUS in the same cycle as a set event SHALL leave the bit set.

Reset
REQ-028 On presetn_i = 0, the block SHALL immediately go to IDLE and clear all ALARM slots, the counter, the active slot, missed and overlap.
REQ-029 On reset, CFG SHALL load snooze_min = 5 and timeout_min = 10.
REQ-030 During reset, ring_o, irq_o, pslverr_o and prdata_o SHALL be 0.
REQ-031 Asserting reset mid-ring SHALL drop ring_o asynchronously.

Verification
REQ-032 ALARM1 = 0x10730 and time_now_i = 0x0730 with a tick -> ring_o = 1 next cycle, STATUS = 0x05.
REQ-033 ALARM0 and ALARM2 both set to 0x10600 and matched -> active slot 0; a second match while ringing -> overlap = 1 and irq_o = 1.
REQ-034 Ringing with snooze_btn_i pulse -> SNOOZE; after 5 ticks -> RINGING; stop_btn_i and snooze_btn_i in the same cycle -> IDLE.
REQ-035 CFG timeout_min = 2 while ringing with 2 ticks -> IDLE, missed = 1; write 0x10 to STATUS -> missed = 0 and irq_o = 0.
REQ-036 Read 0x1C or 0x02 -> pslverr_o = 1, prdata_o = 0; write with pstrb_i = 0001 -> only byte 0 changes.
REQ-037 presetn_i pulsed low during RINGING -> ring_o = 0 immediately; CFG reads 0x0A05.
